// File: rtl/matrix_vector_stream.sv
// rtl/matrix_vector_stream.sv - captures an NxN matrix and streams its slices or transposed rows
module matrix_vector_stream #(
    parameter int DW = 16,
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [N*N*DW-1:0]     Matrix,
    output logic                  busy,
    output logic [N*DW-1:0]       out_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_idx,
    output logic                  out_last,
    output logic                  finish
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N*N*DW-1:0]     buf_q, buf_d;
    logic                  mode_q, mode_d;
    logic [IW-1:0]         idx_q, idx_d;

    logic                  accept;
    logic                  idx_last;

    assign accept   = (state_q == S_STREAM) && out_ready;
    assign idx_last = (idx_q == IW'(N - 1));

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DONE always lasts a single cycle before returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: if (accept && idx_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state only.
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_STREAM);
        out_last  = (state_q == S_STREAM) && idx_last;
        finish    = (state_q == S_DONE);
    end

    // Buffer, mode and index next values; Matrix is only looked at on the capture cycle.
    always_comb begin
        buf_d  = buf_q;
        mode_d = mode_q;
        idx_d  = idx_q;
        if ((state_q == S_IDLE) && start) begin
            buf_d  = Matrix;
            mode_d = mode;
            idx_d  = '0;
        end else if (accept && !idx_last) begin
            idx_d  = idx_q + 1'b1;
        end
    end

    // Datapath registers, cleared by reset so out_vec reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            mode_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            mode_q <= mode_d;
            idx_q  <= idx_d;
        end
    end

    // Vector select: slice idx (mode 0) or element idx of every slice (mode 1).
    always_comb begin
        out_vec = '0;
        for (int j = 0; j < N; j++) begin
            if (mode_q) begin
                out_vec[(N-1-j)*DW +: DW] = buf_q[(N*N-1-(j*N+int'(idx_q)))*DW +: DW];
            end else begin
                out_vec[(N-1-j)*DW +: DW] = buf_q[(N*N-1-(int'(idx_q)*N+j))*DW +: DW];
            end
        end
    end

    assign out_idx = idx_q;

endmodule

// File: tb/tb_matrix_vector_stream.sv
// tb/tb_matrix_vector_stream.sv - randomized self-checking bench for matrix_vector_stream
module tb_matrix_vector_stream;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    typedef logic [0:N-1][0:N-1][DW-1:0] mtx_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            mode;
    mtx_t            mtx;
    logic            busy;
    logic [N*DW-1:0] out_vec;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_idx;
    logic            out_last;
    logic            finish;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_vector_stream #(.DW(DW), .N(N), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .Matrix    (mtx),
        .busy      (busy),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .finish    (finish)
    );

    // Reference: slice k, or element k of every slice, first element leftmost.
    function automatic logic [N*DW-1:0] exp_vec(input mtx_t m, input logic md, input int k);
        logic [0:N-1][DW-1:0] v;
        for (int j = 0; j < N; j++) v[j] = md ? m[j][k] : m[k][j];
        return v;
    endfunction

    function automatic mtx_t spec_mtx();
        mtx_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = 8'(i * 16 + j);
        return m;
    endfunction

    function automatic mtx_t rand_mtx();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // status = {busy, out_valid, out_last, finish, out_idx}
    function automatic logic [5:0] st_stream(input int k);
        return {1'b1, 1'b1, (k == N-1), 1'b0, 2'(k)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 1'b1; out_ready = 1'b1; mtx = rand_mtx();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid, out_last, finish, out_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status got %b want %b", {busy, out_valid, out_last, finish, out_idx}, 6'b0);
        end
        checks++;
        if (out_vec !== '0) begin
            errors++;
            $display("FAIL reset_vec got %h want 0", out_vec);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed(input logic md);
        logic [31:0] tbl [4];
        if (md) tbl = '{32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333};
        else    tbl = '{32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233};
        mtx = spec_mtx(); mode = md; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mtx = rand_mtx();
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({busy, out_valid, out_last, finish, out_idx} !== st_stream(k)) begin
                errors++;
                $display("FAIL fixed_m%0d_status k=%0d got %b want %b", md, k,
                         {busy, out_valid, out_last, finish, out_idx}, st_stream(k));
            end
            checks++;
            if (out_vec !== tbl[k]) begin
                errors++;
                $display("FAIL fixed_m%0d_vec k=%0d got %h want %h", md, k, out_vec, tbl[k]);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, out_valid, finish} !== 3'b101) begin
            errors++;
            $display("FAIL fixed_m%0d_done got bvf=%b want 101", md, {busy, out_valid, finish});
        end
        @(negedge clk);
        checks++;
        if ({busy, out_valid, finish} !== 3'b000) begin
            errors++;
            $display("FAIL fixed_m%0d_idle got bvf=%b want 000", md, {busy, out_valid, finish});
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int low = 0;
        logic [31:0] want1 = 32'h10111213;
        mtx = spec_mtx(); mode = 1'b0; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!finish && cyc < 30) begin
            if (out_valid && out_idx == 2'd1) begin
                checks++;
                if (out_vec !== want1 || out_last !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold cyc=%0d got %h last=%b want %h last=0", cyc, out_vec, out_last, want1);
                end
            end
            if (out_valid && out_idx == 2'd1 && low < 3) begin
                out_ready = 1'b0;
                low++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_finish_delay got %0d want 8", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        mtx_t m0 = rand_mtx();
        logic md = 1'($urandom);
        int k = 0;
        int fin = 0;
        mtx = m0; mode = md; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            start = 1'b0;
            if (out_valid) begin
                checks++;
                if (out_idx !== 2'(k) || out_vec !== exp_vec(m0, md, k)) begin
                    errors++;
                    $display("FAIL ign_vec k=%0d got idx=%0d %h want %h", k, out_idx, out_vec, exp_vec(m0, md, k));
                end
                if (k == 1) begin
                    mtx = rand_mtx(); mode = ~md; start = 1'b1;
                end
                k++;
            end
            if (finish) fin++;
            @(negedge clk);
        end
        checks++;
        if (fin !== 1 || k !== N || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_summary got fin=%0d vecs=%0d busy=%b want 1 4 0", fin, k, busy);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int guard = 0;
        mtx = rand_mtx(); mode = 1'($urandom); out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(out_valid && out_idx == 2'd2) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, out_valid, out_last, finish, out_idx} !== 6'b0 || out_vec !== '0 || guard !== 2) begin
            errors++;
            $display("FAIL rst_mid got st=%b vec=%h guard=%0d want 0 0 2",
                     {busy, out_valid, out_last, finish, out_idx}, out_vec, guard);
        end
        for (int c = 0; c < 8; c++) begin
            if (finish || out_valid) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        mtx_t m0 = rand_mtx();
        logic md = 1'($urandom);
        mtx = m0; mode = md; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if ({busy, out_valid, out_last, finish, out_idx} !== st_stream(k) ||
                    out_vec !== exp_vec(m0, md, k)) begin
                    errors++;
                    $display("FAIL b2b r=%0d k=%0d got st=%b %h want st=%b %h", r, k,
                             {busy, out_valid, out_last, finish, out_idx}, out_vec,
                             st_stream(k), exp_vec(m0, md, k));
                end
                @(negedge clk);
            end
            checks++;
            if ({busy, out_valid, finish} !== 3'b101) begin
                errors++;
                $display("FAIL b2b_done r=%0d got %b want 101", r, {busy, out_valid, finish});
            end
            @(negedge clk);
            checks++;
            if ({busy, out_valid, finish} !== 3'b000) begin
                errors++;
                $display("FAIL b2b_idle r=%0d got %b want 000", r, {busy, out_valid, finish});
            end
            if (r == 2) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            mtx_t m0 = rand_mtx();
            logic md = 1'($urandom);
            int k = 0;
            int cyc = 0;
            mtx = m0; mode = md; out_ready = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (k < N && cyc < 200) begin
                checks++;
                if ({busy, out_valid, out_last, finish, out_idx} !== st_stream(k) ||
                    out_vec !== exp_vec(m0, md, k)) begin
                    errors++;
                    $display("FAIL rnd it=%0d k=%0d got st=%b %h want st=%b %h", it, k,
                             {busy, out_valid, out_last, finish, out_idx}, out_vec,
                             st_stream(k), exp_vec(m0, md, k));
                end
                out_ready = 1'($urandom_range(0, 1));
                mtx = rand_mtx();
                if (out_ready) k++;
                @(negedge clk);
                cyc++;
            end
            out_ready = 1'b0;
            checks++;
            if (k !== N || {busy, out_valid, finish} !== 3'b101) begin
                errors++;
                $display("FAIL rnd_done it=%0d got k=%0d bvf=%b want 4 101", it, k, {busy, out_valid, finish});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0; mtx = '0;
        @(negedge clk);
        test_reset();
        test_fixed(1'b0);
        test_fixed(1'b1);
        test_backpressure();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_vector_stream.md
MATRIX_VECTOR_STREAM -- requirements
Module: matrix_vector_stream

Interface
REQ-001 Parameter DW, default 16, element width in bits (DW >= 1).
REQ-002 Parameter N, default 16, matrix dimension: N x N elements, N vectors per matrix (N >= 2).
REQ-003 Parameter IW, default 4, index width = clog2(N); the instantiating module sets it consistently with N.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to capture Matrix and mode and begin streaming.
REQ-007 mode  input  1  0 = slice (column) streaming, 1 = transposed (row) streaming.
REQ-008 Matrix  input  N*N*DW  signed packed matrix; element e(i,j) at bits [(N*N-1-(i*N+j))*DW +: DW], slice 0 in the MSBs.
REQ-009 busy  output  1  high whenever the block is not IDLE; start is ignored while busy.
REQ-010 out_vec  output  N*DW  signed current vector, first element in the MSBs.
REQ-011 out_valid  output  1  out_vec holds a valid vector.
REQ-012 out_ready  input  1  consumer accepts out_vec when out_valid and out_ready are both high.
REQ-013 out_idx  output  IW  index k of the vector on out_vec.
REQ-014 out_last  output  1  high with out_valid when out_idx == N-1.
REQ-015 finish  output  1  one-cycle pulse after the last vector is accepted.

Function
REQ-016 States: IDLE, STREAM, DONE.
REQ-017 IDLE and start=1: capture Matrix into internal buffer and mode into mode_q, clear out_idx to 0, enter STREAM; Matrix is not sampled at any other time.
REQ-018 Latency: start sampled at edge t gives out_valid=1 with vector 0 after edge t, i.e. in cycle t+1.
REQ-019 mode_q=0: out_vec for index k = {e(k,0), e(k,1), ..., e(k,N-1)} (slice k).
REQ-020 mode_q=1: out_vec for index k = {e(0,k), e(1,k), ..., e(N-1,k)} (gather element k of every slice).
REQ-021 out_vec is a function of the captured buffer, mode_q and out_idx only; Matrix changes after capture have no effect.
REQ-022 STREAM: out_valid=1; on out_valid&&out_ready with out_idx<N-1, out_idx increments by 1.
REQ-023 STREAM: on out_valid&&out_ready with out_idx==N-1, enter DONE; out_idx does not wrap during STREAM.
REQ-024 Back-pressure: while out_ready=0, out_vec, out_idx, out_last and out_valid remain unchanged for any number of cycles.
REQ-025 DONE: out_valid=0, finish=1 for exactly one cycle, then IDLE; finish=0 in all other states.
REQ-026 start in STREAM or DONE is ignored with no effect; start in IDLE in the cycle after DONE begins a new matrix (back-to-back spacing of 2 idle-side cycles).
REQ-027 out_valid=0 in IDLE and DONE; out_vec is don't-care when out_valid=0 but holds the last value (no X).
REQ-028 Elements are passed bit-exact; no arithmetic, no sign extension, no truncation.

Reset
REQ-029 rst=1 at an edge: state IDLE, busy=0, out_valid=0, out_last=0, finish=0, out_idx=0, out_vec=0, mode_q=0, buffer cleared to 0.
REQ-030 rst has priority over start and out_ready in the same cycle.
REQ-031 rst during STREAM abandons the matrix: no further vectors and no finish pulse.
REQ-032 No initial blocks are used for state; reset is the only initialisation.

Verification (N=4, DW=8, e(i,j)=8'h{i}{j}, e.g. e(2,1)=8'h21)
REQ-033 mode=0, start pulse, out_ready=1 -> out_vec 32'h00010203, 32'h10111213, 32'h20212223, 32'h30313233 on consecutive cycles, out_last on the 4th, finish one cycle later.
REQ-034 mode=1, same matrix -> out_vec 32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333; out_idx 0..3.
REQ-035 out_ready low for 3 cycles at idx 1 -> 32'h10111213 with idx 1 held stable for 3 cycles; total finish delay grows by exactly 3 cycles.
REQ-036 Matrix changed and start pulsed during STREAM -> stream unaffected, no restart, single finish pulse.
REQ-037 rst asserted at idx 2 -> next cycle out_valid=0, busy=0, out_idx=0, out_vec=0; finish never asserted.
REQ-038 start held high continuously with out_ready=1 -> streams repeat with vector 0 one cycle after the finish cycle ends; every sequence is complete and in order.
